alu_arbiter: RTL
================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter: LATENCY, default 1, ALU result-register latency in cycles (legal 1..15).
REQ-002 CLK  input  1  system clock, all state updates on rising edge.
REQ-003 RESET  input  1  synchronous, active-high reset, sampled on rising CLK.
REQ-004 REQ_0, REQ_1  input  1 each  requester 0/1 operation request, level, held until own GNT seen.
REQ-005 A_0, B_0, A_1, B_1  input  8 each  requester operands.
REQ-006 OP_0, OP_1  input  4 each  requester ALU op code.
REQ-007 GNT_0, GNT_1  output  1 each  one-cycle pulse: request accepted, operands latched.
REQ-008 DONE_0, DONE_1  output  1 each  one-cycle pulse: RESULT valid for that requester.
REQ-009 RESULT  output  8  last completed result, held until next completion.
REQ-010 BUSY  output  1  high whenever state is not IDLE.
REQ-011 ALU_A, ALU_B  output  8 each  operands driven to shared ALU.
REQ-012 ALU_OP  output  4  op code driven to shared ALU.
REQ-013 ALU_RESULT  input  8  shared ALU registered output.

Function
REQ-014 FSM states SHALL be IDLE, ISSUE, WAIT, DONE; all outputs registered.
REQ-015 IDLE: no request -> stay IDLE; any request -> winner chosen, its A/B/OP latched into ALU_A/ALU_B/ALU_OP, owner tag stored, go ISSUE.
REQ-016 Arbitration SHALL be round-robin: single request wins; both requesting -> requester not served last wins; after reset requester 0 has priority.
REQ-017 ISSUE lasts exactly one cycle with GNT of owner = 1; WAIT counter loaded with LATENCY; go WAIT.
REQ-018 WAIT SHALL last exactly LATENCY cycles; on the edge ending the last WAIT cycle, RESULT <= ALU_RESULT; go DONE.
REQ-019 DONE lasts one cycle with DONE of owner = 1; round-robin pointer updated to owner; go IDLE.
REQ-020 Timing (LATENCY=1): request in IDLE cycle t -> GNT cycle t+1, DONE and RESULT valid cycle t+3, IDLE t+4; next GNT no earlier than t+5.
REQ-021 ALU_A/ALU_B/ALU_OP SHALL hold latched values from ISSUE until the next ISSUE; requester input changes after grant SHALL NOT affect the in-flight result.
REQ-022 Requests are sampled only in IDLE; REQ levels during ISSUE/WAIT/DONE are ignored, not queued.
REQ-023 A requester holding REQ past its DONE is re-arbitrated in the next IDLE; a sole continuous requester is served back-to-back.
REQ-024 GNT_0/GNT_1 SHALL never be high together; same for DONE_0/DONE_1; at most one operation in flight.
REQ-025 LATENCY outside 1..15 is unsupported; no runtime check required.

Reset
REQ-026 RESET SHALL force state IDLE, pointer to requester 0, GNT/DONE/BUSY = 0, RESULT/ALU_A/ALU_B = 8'h00, ALU_OP = 4'h0, WAIT counter 0.
REQ-027 RESET asserted in any state, including mid-operation, SHALL abort it with no DONE pulse; RESET has priority over all transitions.
REQ-028 First request is accepted in the first cycle after RESET deasserts.

Verification
REQ-029 Reset: hold RESET 2 cycles, REQ_0=REQ_1=1 -> all outputs zero, no GNT during reset, GNT_0 one cycle after release.
REQ-030 Single op: REQ_0, A_0=8'h05, B_0=8'h03, OP_0=4'h0 in cycle t -> GNT_0 at t+1, DONE_0 at t+3, RESULT=8'h08, BUSY high t+1..t+3.
REQ-031 Contention: both request at t (OP_0=4'h1, 8'h0A/8'h03; OP_1=4'h2, 8'h04/8'h05) -> DONE_0 t+3 RESULT=8'h07; GNT_1 t+5, DONE_1 t+7 RESULT=8'h14.
REQ-032 Fairness: REQ_0 and REQ_1 held high 6 ops -> grant order 0,1,0,1,0,1, never simultaneous.
REQ-033 Abort: RESET pulsed in WAIT -> no DONE, RESULT=8'h00 next cycle, next request served normally.
REQ-034 Operand isolation: change A_0 to 8'hFF after GNT_0 (OP=4'h5, A_0=8'h10) -> RESULT=8'h11; repeat with LATENCY=3 -> DONE at t+5.

Source files
------------

// File: rtl/alu_arbiter.sv
// alu_arbiter: two-requester round-robin front end for a shared, registered ALU.
// One operation is in flight at a time: IDLE -> ISSUE -> WAIT (LATENCY cycles) -> DONE.
module alu_arbiter #(
    parameter int LATENCY = 1
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       REQ_0,
    input  logic       REQ_1,
    input  logic [7:0] A_0,
    input  logic [7:0] B_0,
    input  logic [7:0] A_1,
    input  logic [7:0] B_1,
    input  logic [3:0] OP_0,
    input  logic [3:0] OP_1,
    output logic       GNT_0,
    output logic       GNT_1,
    output logic       DONE_0,
    output logic       DONE_1,
    output logic [7:0] RESULT,
    output logic       BUSY,
    output logic [7:0] ALU_A,
    output logic [7:0] ALU_B,
    output logic [3:0] ALU_OP,
    input  logic [7:0] ALU_RESULT
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    localparam logic [3:0] LAT = 4'(LATENCY);

    state_t     state;
    state_t     state_next;
    logic       owner;        // requester whose operation is in flight
    logic       owner_next;
    logic       prio;         // requester that wins when both request together
    logic       prio_next;
    logic [3:0] cnt;          // remaining WAIT cycles
    logic [3:0] cnt_next;
    logic [7:0] alu_a_next;
    logic [7:0] alu_b_next;
    logic [3:0] alu_op_next;
    logic [7:0] result_next;
    logic       win;

    // Next-state, arbitration and datapath-load decisions.
    always_comb begin
        state_next  = state;
        owner_next  = owner;
        prio_next   = prio;
        cnt_next    = cnt;
        alu_a_next  = ALU_A;
        alu_b_next  = ALU_B;
        alu_op_next = ALU_OP;
        result_next = RESULT;
        win         = 1'b0;
        case (state)
            IDLE: begin
                if (REQ_0 || REQ_1) begin
                    // A lone requester always wins; a tie goes to the priority holder.
                    win         = (REQ_0 && REQ_1) ? prio : REQ_1;
                    owner_next  = win;
                    alu_a_next  = win ? A_1  : A_0;
                    alu_b_next  = win ? B_1  : B_0;
                    alu_op_next = win ? OP_1 : OP_0;
                    state_next  = ISSUE;
                end
            end
            ISSUE: begin
                cnt_next   = LAT;
                state_next = WAIT;
            end
            WAIT: begin
                cnt_next = cnt - 4'd1;
                if (cnt == 4'd1) begin
                    result_next = ALU_RESULT;
                    state_next  = DONE;
                end
            end
            DONE: begin
                // The requester just served loses the next tie.
                prio_next  = ~owner;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // State and registered outputs; reset aborts any operation without a DONE pulse.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state  <= IDLE;
            owner  <= 1'b0;
            prio   <= 1'b0;
            cnt    <= 4'd0;
            ALU_A  <= 8'h00;
            ALU_B  <= 8'h00;
            ALU_OP <= 4'h0;
            RESULT <= 8'h00;
            GNT_0  <= 1'b0;
            GNT_1  <= 1'b0;
            DONE_0 <= 1'b0;
            DONE_1 <= 1'b0;
            BUSY   <= 1'b0;
        end else begin
            state  <= state_next;
            owner  <= owner_next;
            prio   <= prio_next;
            cnt    <= cnt_next;
            ALU_A  <= alu_a_next;
            ALU_B  <= alu_b_next;
            ALU_OP <= alu_op_next;
            RESULT <= result_next;
            GNT_0  <= (state_next == ISSUE) && !owner_next;
            GNT_1  <= (state_next == ISSUE) &&  owner_next;
            DONE_0 <= (state_next == DONE)  && !owner_next;
            DONE_1 <= (state_next == DONE)  &&  owner_next;
            BUSY   <= (state_next != IDLE);
        end
    end

endmodule
